// File: rtl/scan_harness.sv
// Pin-reduction harness: serial stimulus chain with update register driving a wide DUT,
// and a response chain that reads back either the raw response or a MISR signature.
module scan_harness #(
  parameter int IN_BITS    = 512,
  parameter int OUT_BITS   = 528,
  parameter int LANES      = 1,
  parameter int MISR_WIDTH = 32,
  parameter logic [MISR_WIDTH-1:0] MISR_POLY = MISR_WIDTH'(32'h04C11DB7)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [LANES-1:0]    si,
  input  logic [1:0]          cmd,
  input  logic                misr_en,
  input  logic                cap_sig,
  input  logic [OUT_BITS-1:0] resp,
  output logic [IN_BITS-1:0]  stim,
  output logic [LANES-1:0]    so,
  output logic                shift_done
);

  localparam int IN_BEATS  = (IN_BITS + LANES - 1) / LANES;
  localparam int IN_PAD    = IN_BEATS * LANES;
  localparam int OUT_BEATS = (OUT_BITS + LANES - 1) / LANES;
  localparam int OUT_PAD   = OUT_BEATS * LANES;
  localparam int MAX_BEATS = (IN_BEATS > OUT_BEATS) ? IN_BEATS : OUT_BEATS;
  localparam int CNT_W     = $clog2(MAX_BEATS + 1);
  localparam int FOLD_N    = (OUT_BITS + MISR_WIDTH - 1) / MISR_WIDTH;
  localparam int FOLD_PAD  = FOLD_N * MISR_WIDTH;
  localparam int EXT_W     = (OUT_PAD > MISR_WIDTH) ? OUT_PAD : MISR_WIDTH;

  localparam logic [1:0] CMD_SHIFT   = 2'b01;
  localparam logic [1:0] CMD_CAPTURE = 2'b10;
  localparam logic [1:0] CMD_UPDATE  = 2'b11;

  logic [IN_PAD-1:0]     sc;
  logic [OUT_PAD-1:0]    rc;
  logic [MISR_WIDTH-1:0] sig;
  logic [CNT_W-1:0]      cnt;
  logic [OUT_PAD-1:0]    cap_data;

  // XOR of all MISR_WIDTH slices of the response, top slice zero-padded.
  function automatic logic [MISR_WIDTH-1:0] fold_resp(input logic [OUT_BITS-1:0] r);
    logic [FOLD_PAD-1:0]   padded;
    logic [MISR_WIDTH-1:0] acc;
    padded = FOLD_PAD'(r);
    acc    = '0;
    for (int i = 0; i < FOLD_N; i++) begin
      acc = acc ^ padded[i*MISR_WIDTH +: MISR_WIDTH];
    end
    return acc;
  endfunction

  function automatic logic [MISR_WIDTH-1:0] misr_step(input logic [MISR_WIDTH-1:0] s,
                                                      input logic [MISR_WIDTH-1:0] f);
    return (s << 1) ^ (s[MISR_WIDTH-1] ? MISR_POLY : '0) ^ f;
  endfunction

  // Signature is zero-extended, or truncated when wider than the readout chain.
  function automatic logic [OUT_PAD-1:0] sig_to_chain(input logic [MISR_WIDTH-1:0] s);
    logic [EXT_W-1:0] wide;
    wide = EXT_W'(s);
    return wide[OUT_PAD-1:0];
  endfunction

  assign cap_data   = cap_sig ? sig_to_chain(sig) : OUT_PAD'(resp);
  assign shift_done = (cnt == CNT_W'(MAX_BEATS));

  always_ff @(posedge clk) begin
    if (rst) begin
      sc   <= '0;
      rc   <= '0;
      stim <= '0;
      so   <= '0;
      sig  <= '0;
      cnt  <= '0;
    end else begin
      if (misr_en) begin
        sig <= misr_step(sig, fold_resp(resp));
      end
      case (cmd)
        CMD_SHIFT: begin
          sc <= (sc << LANES) | IN_PAD'(si);
          so <= rc[OUT_PAD-1 -: LANES];
          rc <= rc << LANES;
          if (!shift_done) begin
            cnt <= cnt + 1'b1;
          end
        end
        CMD_CAPTURE: begin
          rc  <= cap_data;
          cnt <= '0;
        end
        CMD_UPDATE: begin
          stim <= sc[IN_BITS-1:0];
          cnt  <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
